// File: rtl/wiredleg_mul_pkg.sv
// wiredleg_mul_pkg: shared widths and latency helper for the iterative multiplier
package wiredleg_mul_pkg;
  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;
  function automatic int mul_steps(input int step_bits);
    return MUL_W / step_bits;
  endfunction
endpackage

// File: rtl/wiredleg_mul_simp_if.sv
// wiredleg_mul_simp_if: start/sign/busy issue contract shared with the divider
interface wiredleg_mul_simp_if;
  import wiredleg_mul_pkg::*;
  logic [MUL_W-1:0] A;
  logic [MUL_W-1:0] B;
  logic             start;
  logic             sign;
  logic             busy;
  logic             done;
  logic [MUL_W-1:0] prod_lo;
  logic [MUL_W-1:0] prod_hi;
  modport master (output A, B, start, sign, input busy, done, prod_lo, prod_hi);
  modport slave  (input A, B, start, sign, output busy, done, prod_lo, prod_hi);
endinterface

// File: rtl/wiredleg_mul_step.sv
// wiredleg_mul_step: one shift-add retirement of STEP_BITS multiplier bits
module wiredleg_mul_step
  import wiredleg_mul_pkg::*;
#(
  parameter int STEP_BITS = 2
) (
  input  logic [PROD_W-1:0]    acc,
  input  logic [PROD_W-1:0]    mcand,
  input  logic [STEP_BITS-1:0] chunk,
  output logic [PROD_W-1:0]    acc_nxt
);
  assign acc_nxt = acc + mcand * PROD_W'(chunk);
endmodule

// File: rtl/wiredleg_mul_simp.sv
// wiredleg_mul_simp: fixed-latency 32x32 signed/unsigned multiplier, 32/STEP_BITS cycles
module wiredleg_mul_simp
  import wiredleg_mul_pkg::*;
#(
  parameter int STEP_BITS = 2
) (
  input logic               clk,
  input logic               rst_n,
  wiredleg_mul_simp_if.slave m
);
  localparam int N  = mul_steps(STEP_BITS);
  localparam int TW = $clog2(N + 1);
  logic [PROD_W-1:0] mcand_q, acc_q, acc_nxt, prod;
  logic [MUL_W-1:0]  mplier_q, a_abs, b_abs;
  logic [TW-1:0]     timer_q;
  logic              busy_q, done_q, neg_q;
  assign a_abs = (m.sign && m.A[MUL_W-1]) ? -m.A : m.A;
  assign b_abs = (m.sign && m.B[MUL_W-1]) ? -m.B : m.B;
  wiredleg_mul_step #(.STEP_BITS(STEP_BITS)) u_step (
    .acc    (acc_q),
    .mcand  (mcand_q),
    .chunk  (mplier_q[STEP_BITS-1:0]),
    .acc_nxt(acc_nxt)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else if (m.start) begin
      mcand_q  <= {{(PROD_W-MUL_W){1'b0}}, a_abs};
      mplier_q <= b_abs;
      acc_q    <= '0;
      timer_q  <= TW'(N);
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      neg_q    <= m.sign && (m.A[MUL_W-1] ^ m.B[MUL_W-1]);
    end else if (timer_q != '0) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << STEP_BITS;
      mplier_q <= mplier_q >> STEP_BITS;
      timer_q  <= timer_q - 1'b1;
      busy_q   <= timer_q != TW'(1);
      done_q   <= timer_q == TW'(1);
    end else begin
      done_q   <= 1'b0;
    end
  end
  // magnitudes are accumulated, sign is restored on the way out
  assign prod      = neg_q ? -acc_q : acc_q;
  assign m.busy    = busy_q;
  assign m.done    = done_q;
  assign m.prod_lo = prod[MUL_W-1:0];
  assign m.prod_hi = prod[PROD_W-1:MUL_W];
endmodule

// File: tb/tb_wiredleg_mul_simp.sv
// tb_wiredleg_mul_simp: directed checks of three instances (STEP_BITS 1, 2, 4) driven in lockstep
module tb_wiredleg_mul_simp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_t = '0, b_t = '0;
  logic        start_t = 1'b0, sign_t = 1'b0;
  logic        busy_v [3];
  logic        done_v [3];
  logic [63:0] prod_v [3];
  int          done_cnt [3];
  int          done_at [3];
  int          busy_cnt [3];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    wiredleg_mul_simp_if mif ();
    assign mif.A     = a_t;
    assign mif.B     = b_t;
    assign mif.start = start_t;
    assign mif.sign  = sign_t;
    assign busy_v[g] = mif.busy;
    assign done_v[g] = mif.done;
    assign prod_v[g] = {mif.prod_hi, mif.prod_lo};
    wiredleg_mul_simp #(.STEP_BITS(1 << g)) dut (.clk(clk), .rst_n(rst_n), .m(mif.slave));
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    a_t = a; b_t = b; sign_t = s; start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
  endtask
  task automatic watch(input int cycles);
    for (int g = 0; g < 3; g++) begin
      done_cnt[g] = 0; done_at[g] = 0; busy_cnt[g] = 0;
    end
    for (int k = 1; k <= cycles; k++) begin
      if (k > 1) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (done_v[g]) begin done_cnt[g]++; done_at[g] = k; end
        busy_cnt[g] += int'(busy_v[g]);
      end
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp);
    launch(a, b, s);
    watch(40);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s_prod_%0d", tag, g), prod_v[g], exp);
      check($sformatf("%s_ndone_%0d", tag, g), 64'(done_cnt[g]), 64'd1);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_busy_%0d", g), 64'(busy_v[g]), 64'd0);
      check($sformatf("rst_done_%0d", g), 64'(done_v[g]), 64'd0);
      check($sformatf("rst_prod_%0d", g), prod_v[g], 64'd0);
    end
    rst_n = 1'b1;
    run_op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("lat_done_%0d", g), 64'(done_at[g]), 64'(32 / (1 << g) + 1));
      check($sformatf("lat_busy_%0d", g), 64'(busy_cnt[g]), 64'(32 / (1 << g)));
    end
    run_op("m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1);
    run_op("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
    run_op("minxmin", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
    run_op("minx1_s", 32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000);
    run_op("minx1_u", 32'h80000000, 32'd1, 1'b0, 64'h00000000_80000000);
    run_op("zero_u", 32'd0, 32'h12345678, 1'b0, 64'd0);
    run_op("zero_s", 32'd0, 32'h12345678, 1'b1, 64'd0);
    // restart: second start lands three edges into 7*9
    launch(32'd7, 32'd9, 1'b0);
    @(negedge clk);
    a_t = 32'h10000; b_t = 32'h10000; start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    watch(40);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rs_prod_%0d", g), prod_v[g], 64'h00000001_00000000);
      check($sformatf("rs_ndone_%0d", g), 64'(done_cnt[g]), 64'd1);
    end
    // reset mid-operation
    launch(32'd123, 32'd456, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("mr_busy_%0d", g), 64'(busy_v[g]), 64'd0);
      check($sformatf("mr_done_%0d", g), 64'(done_v[g]), 64'd0);
      check($sformatf("mr_prod_%0d", g), prod_v[g], 64'd0);
    end
    rst_n = 1'b1;
    watch(40);
    for (int g = 0; g < 3; g++)
      check($sformatf("mr_nodone_%0d", g), 64'(done_cnt[g]), 64'd0);
    run_op("after_rst", 32'd11, 32'd13, 1'b0, 64'd143);
    // back-to-back on the STEP_BITS=2 instance
    launch(32'd6, 32'd7, 1'b0);
    for (int k = 0; k < 40 && !done_v[1]; k++) @(negedge clk);
    check("b2b_done1", 64'(done_v[1]), 64'd1);
    check("b2b_prod1", prod_v[1], 64'd42);
    a_t = 32'd2; b_t = 32'd3; start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    check("b2b_drop", 64'(done_v[1]), 64'd0);
    check("b2b_busy", 64'(busy_v[1]), 64'd1);
    watch(30);
    check("b2b_ndone2", 64'(done_cnt[1]), 64'd1);
    check("b2b_at2", 64'(done_at[1]), 64'd17);
    check("b2b_prod2", prod_v[1], 64'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
